// File: rtl/repetition_encoder_tx.sv
// Serial repetition-code transmitter: sends each bit of a captured word LSB-first
// as REP identical chips over a valid/ready chip stream.
module repetition_encoder_tx #(
  parameter int DATA_W = 8,
  parameter int REP    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_chip,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_last,
  output logic              busy
);

  localparam int RW = (REP > 1) ? $clog2(REP) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [RW-1:0] REP_LAST = RW'(REP - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] sr;
  logic [RW-1:0]     rep_cnt;
  logic [BW-1:0]     bit_cnt;
  logic              accept, xfer;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // All outputs are decodes of state and registered datapath, never of in_valid.
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    tx_valid = 1'b0;
    busy     = 1'b0;
    tx_chip  = 1'b0;
    tx_last  = 1'b0;
    accept   = 1'b0;
    xfer     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) state_nx = SEND;
      end
      SEND: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_chip  = sr[0];
        tx_last  = (bit_cnt == BIT_LAST) && (rep_cnt == REP_LAST);
        xfer     = tx_ready;
        if (tx_ready && tx_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt <= '0;
      bit_cnt <= '0;
    end else if (accept) begin
      sr      <= in_data;
      rep_cnt <= '0;
      bit_cnt <= '0;
    end else if (xfer) begin
      if (rep_cnt == REP_LAST) begin
        rep_cnt <= '0;
        sr      <= sr >> 1;
        // Clear instead of wrapping once the final bit has gone out.
        bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
      end else begin
        rep_cnt <= rep_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_repetition_encoder_tx.sv
// Directed bench for repetition_encoder_tx: default instance plus two parameter
// variants decoded by majority vote.
module tb_repetition_encoder_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid, in_ready, tx_chip, tx_valid, tx_ready, tx_last, busy;

  logic [0:0] a_data;
  logic       a_valid, a_ready, a_chip, a_tvalid, a_tready, a_last, a_busy;
  logic [15:0] b_data;
  logic       b_valid, b_ready, b_chip, b_tvalid, b_tready, b_last, b_busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  repetition_encoder_tx #(.DATA_W(8), .REP(16)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .tx_chip(tx_chip), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last), .busy(busy)
  );

  repetition_encoder_tx #(.DATA_W(1), .REP(2)) dut_a (
    .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .tx_chip(a_chip), .tx_valid(a_tvalid), .tx_ready(a_tready), .tx_last(a_last), .busy(a_busy)
  );

  repetition_encoder_tx #(.DATA_W(16), .REP(3)) dut_b (
    .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
    .tx_chip(b_chip), .tx_valid(b_tvalid), .tx_ready(b_tready), .tx_last(b_last), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: in_valid low during SEND; 1: in_valid held high with in_data=nxt;
  // 2: in_valid high with random in_data every cycle, dropped once back in IDLE.
  task automatic send_word(input logic [7:0] w, input bit rnd, input int mode,
                           input logic [7:0] nxt, input string tag);
    int   n = 0;
    int   cyc = 0;
    logic pstall = 1'b0;
    logic pchip = 1'b0;
    in_data  = w;
    in_valid = 1'b1;
    chk({tag, "_in_ready_idle"}, in_ready, 1);
    tick();
    in_valid = (mode != 0);
    in_data  = nxt;
    while (n < 128 && cyc < 2000) begin
      if (mode == 2) in_data = 8'($urandom);
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      chk({tag, "_tx_valid"}, tx_valid, 1);
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_in_ready_send"}, in_ready, 0);
      if (pstall) chk({tag, "_stall_hold"}, tx_chip, pchip);
      if (tx_ready) begin
        chk({tag, "_chip"}, tx_chip, w[n/16]);
        chk({tag, "_last"}, tx_last, n == 127);
        n++;
        pstall = 1'b0;
      end else begin
        pstall = 1'b1;
        pchip  = tx_chip;
      end
      tick();
      cyc++;
    end
    chk({tag, "_transfers"}, n, 128);
    if (!rnd) chk({tag, "_send_cycles"}, cyc, 128);
    chk({tag, "_done_valid"}, tx_valid, 0);
    chk({tag, "_done_busy"}, busy, 0);
    chk({tag, "_done_in_ready"}, in_ready, 1);
    if (mode == 2) in_valid = 1'b0;
  endtask

  task automatic sweep_a(input logic w);
    int n = 0;
    int cyc = 0;
    int ones = 0;
    a_data  = w;
    a_valid = 1'b1;
    chk("a_in_ready", a_ready, 1);
    tick();
    a_valid = 1'b0;
    while (n < 2 && cyc < 100) begin
      a_tready = 1'($urandom_range(0, 1));
      if (a_tvalid && a_tready) begin
        if (a_chip) ones++;
        chk("a_last", a_last, n == 1);
        n++;
      end
      tick();
      cyc++;
    end
    a_tready = 1'b0;
    chk("a_chip_count", n, 2);
    chk("a_decode", ones >= 2, w);
    chk("a_done_valid", a_tvalid, 0);
    chk("a_done_busy", a_busy, 0);
  endtask

  task automatic sweep_b(input logic [15:0] w);
    int          n = 0;
    int          cyc = 0;
    int          ones [16];
    logic [15:0] dec;
    for (int k = 0; k < 16; k++) ones[k] = 0;
    b_data  = w;
    b_valid = 1'b1;
    chk("b_in_ready", b_ready, 1);
    tick();
    b_valid = 1'b0;
    while (n < 48 && cyc < 500) begin
      b_tready = 1'($urandom_range(0, 1));
      if (b_tvalid && b_tready) begin
        if (b_chip) ones[n/3]++;
        chk("b_last", b_last, n == 47);
        n++;
      end
      tick();
      cyc++;
    end
    b_tready = 1'b0;
    for (int k = 0; k < 16; k++) dec[k] = (ones[k] >= 2);
    chk("b_chip_count", n, 48);
    chk("b_decode", dec, w);
    chk("b_done_valid", b_tvalid, 0);
    chk("b_done_busy", b_busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    in_data = '0; in_valid = 1'b0; tx_ready = 1'b0;
    a_data = '0; a_valid = 1'b0; a_tready = 1'b0;
    b_data = '0; b_valid = 1'b0; b_tready = 1'b0;
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tx_last", tx_last, 0);
    chk("rst_tx_chip", tx_chip, 0);
    chk("rst_a_ready", a_ready, 1);
    chk("rst_b_ready", b_ready, 1);
    rst = 1'b0;
    tick();

    send_word(8'hA5, 1'b0, 0, 8'h00, "t1");
    tick();

    // Back-to-back: second word captured on the single IDLE cycle between them.
    send_word(8'h00, 1'b0, 1, 8'hFF, "t2a");
    send_word(8'hFF, 1'b0, 0, 8'h00, "t2b");
    tick();

    send_word(8'h3C, 1'b1, 0, 8'h00, "t3");
    tick();

    // Reset while the 40th chip is presented.
    in_data  = 8'hFF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tx_ready = 1'b1;
    repeat (39) tick();
    chk("t4_pre_valid", tx_valid, 1);
    chk("t4_pre_chip", tx_chip, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tx_ready = 1'b0;
    chk("t4_rst_valid", tx_valid, 0);
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_in_ready", in_ready, 1);
    chk("t4_rst_chip", tx_chip, 0);
    tick();
    chk("t4_idle_valid", tx_valid, 0);
    send_word(8'h81, 1'b0, 0, 8'h00, "t4");
    tick();

    send_word(8'h5A, 1'b0, 2, 8'h00, "t5");
    tick();
    chk("t5_idle_valid", tx_valid, 0);
    chk("t5_idle_in_ready", in_ready, 1);

    sweep_a(1'b1);
    tick();
    sweep_a(1'b0);
    tick();
    sweep_b(16'hC3A5);
    tick();
    sweep_b(16'h0F01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
